decode_b_pipe: RTL and testbench

- Registered binary-to-one-hot decoder with valid/ready handshake on both sides; the counterpart of the one-hot-to-binary encoder in MISC.
- Drives one-hot select buses (register-file write enables, functional-unit issue selects) from compact binary indices produced upstream.
- Two-entry elastic buffer (output register plus skid register) so upstream back-pressure never drops or duplicates a code.
- Out-of-range codes are flagged, not silently mapped.

---
 rtl/decode_b_pipe.sv | 101 ++++++++++
 tb/tb_decode_b_pipe.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/decode_b_pipe.sv
// Registered binary-to-one-hot decoder with a two-entry elastic buffer
// (output register plus skid register) behind valid/ready handshakes.
module decode_b_pipe #(
  parameter int SEL_WIDTH = 2,
  parameter int N_OUT     = 4
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic [SEL_WIDTH-1:0] code_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic [N_OUT-1:0]     data_out,
  output logic                 err_out,
  output logic                 valid_out,
  input  logic                 ready_in
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  typedef struct packed {
    logic [N_OUT-1:0] data;
    logic             err;
  } entry_t;

  state_e state_q, state_d;
  entry_t oreg_q, oreg_d;
  entry_t sreg_q, sreg_d;
  entry_t dec;
  logic   in_xfer;
  logic   out_xfer;

  function automatic entry_t decode(input logic [SEL_WIDTH-1:0] c);
    entry_t e;
    e.data = '0;
    e.err  = (int'(c) >= N_OUT);
    for (int i = 0; i < N_OUT; i++) begin
      if (int'(c) == i) e.data[i] = 1'b1;
    end
    return e;
  endfunction

  assign dec      = decode(code_in);
  assign in_xfer  = valid_in & ready_out;
  assign out_xfer = valid_out & ready_in;

  // NOTE: storage is cleared on reset so a stale entry can never resurface
  // after a mid-operation reset; the buffers are only two words wide.
  always_ff @(posedge clock_in) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset_in) begin
      state_q <= EMPTY;
      oreg_q  <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      oreg_q  <= oreg_d;
      sreg_q  <= sreg_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal (no latches).
    state_d = state_q;
    oreg_d  = oreg_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          oreg_d  = dec;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          oreg_d = dec;
        end else if (in_xfer) begin
          sreg_d  = dec;
          state_d = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          oreg_d  = sreg_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Outputs depend only on registered state and reset, never on ready_in/valid_in.
  always_comb begin
    ready_out = (state_q != TWO) & ~reset_in;
    valid_out = (state_q != EMPTY) & ~reset_in;
    data_out  = valid_out ? oreg_q.data : '0;
    err_out   = valid_out ? oreg_q.err : 1'b0;
  end

endmodule

// File: tb/tb_decode_b_pipe.sv
// Self-checking bench: two decoders (N_OUT=4 and N_OUT=3) run in lockstep and
// are compared each cycle against a queue-based model of the buffered codes.
module tb_decode_b_pipe;

  logic       clk = 1'b0;
  logic       reset_in;
  logic [1:0] code_in;
  logic       valid_in;
  logic       ready_in;

  logic       ready4, valid4, err4;
  logic [3:0] data4;
  logic       ready3, valid3, err3;
  logic [2:0] data3;

  int total = 0;
  int bad   = 0;
  int step_n = 0;
  int q[$];

  always #5 clk = ~clk;

  decode_b_pipe #(.SEL_WIDTH(2), .N_OUT(4)) dut4 (
    .clock_in (clk),
    .reset_in (reset_in),
    .code_in  (code_in),
    .valid_in (valid_in),
    .ready_out(ready4),
    .data_out (data4),
    .err_out  (err4),
    .valid_out(valid4),
    .ready_in (ready_in)
  );

  decode_b_pipe #(.SEL_WIDTH(2), .N_OUT(3)) dut3 (
    .clock_in (clk),
    .reset_in (reset_in),
    .code_in  (code_in),
    .valid_in (valid_in),
    .ready_out(ready3),
    .data_out (data3),
    .err_out  (err3),
    .valid_out(valid3),
    .ready_in (ready_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_n, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model on the edge, check mid-cycle.
  task automatic step(input bit vi, input int code, input bit ri, input bit rst);
    bit in_x, out_x, exp_v, exp_r;
    int c;
    logic [31:0] exp_d4, exp_d3;
    bit exp_e3;
    valid_in = vi;
    code_in  = code[1:0];
    ready_in = ri;
    reset_in = rst;
    in_x  = vi && !rst && (q.size() < 2);
    out_x = !rst && (q.size() > 0) && ri;
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(code);
    end
    @(negedge clk);
    step_n++;
    exp_v  = !rst && (q.size() > 0);
    exp_r  = !rst && (q.size() < 2);
    c      = exp_v ? q[0] : 0;
    exp_d4 = exp_v ? (32'd1 << c) : 32'd0;
    exp_d3 = (exp_v && c < 3) ? (32'd1 << c) : 32'd0;
    exp_e3 = exp_v && (c >= 3);
    chk("valid4", {31'd0, valid4}, {31'd0, exp_v});
    chk("ready4", {31'd0, ready4}, {31'd0, exp_r});
    chk("data4",  {28'd0, data4},  exp_d4);
    chk("err4",   {31'd0, err4},   32'd0);
    chk("valid3", {31'd0, valid3}, {31'd0, exp_v});
    chk("ready3", {31'd0, ready3}, {31'd0, exp_r});
    chk("data3",  {29'd0, data3},  exp_d3);
    chk("err3",   {31'd0, err3},   {31'd0, exp_e3});
  endtask

  initial begin
    reset_in = 1'b1;
    valid_in = 1'b0;
    code_in  = '0;
    ready_in = 1'b0;
    @(negedge clk);

    // Reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Back-to-back codes 0..3 with downstream always ready
    for (int i = 0; i < 4; i++) step(1, i, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // Out-of-range code on the N_OUT=3 instance, then an in-range one
    step(1, 3, 1, 0);
    step(1, 2, 1, 0);
    step(0, 0, 1, 0);

    // Back-pressure: fill to two entries, third offer blocked, then drain
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // ready_in toggling with continuous valid_in
    for (int i = 0; i < 8; i++) step(1, i % 4, (i % 2) == 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

    // Fill with 3,0 then reset: both entries discarded
    step(1, 3, 0, 0);
    step(1, 0, 0, 0);
    step(1, 2, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // valid_in ignored while in reset
    step(1, 2, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           bit'($urandom_range(0, 3) != 0), $urandom_range(0, 59) == 0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
